// File: rtl/mips_cpu_muldiv_ctrl.sv
// Issue/sequencing controller in front of the HI/LO multiply-divide unit.
// Accepts HI/LO-class SPECIAL instructions, drives the unit, and stalls until the HI/LO write is done.
module mips_cpu_muldiv_ctrl #(
   parameter int MUL_CYCLES  = 2,
   parameter int DIV_TIMEOUT = 48
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_valid,
   input  logic        is_special,
   input  logic [5:0]  funct,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        stall,
   output logic [5:0]  unit_opcode,
   output logic [31:0] unit_a,
   output logic [31:0] unit_b,
   output logic        unit_valid_in,
   input  logic        unit_valid_out,
   input  logic [31:0] hi_in,
   input  logic [31:0] lo_in,
   output logic [31:0] mf_data,
   output logic        mf_valid,
   output logic        div_err
);

   localparam int CNT_MAX = (MUL_CYCLES > DIV_TIMEOUT) ? MUL_CYCLES : DIV_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_TIMEOUT - 1);

   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_MT        = 3'd1;
   localparam logic [2:0] S_MUL       = 3'd2;
   localparam logic [2:0] S_DIV_START = 3'd3;
   localparam logic [2:0] S_DIV_RUN   = 3'd4;
   localparam logic [2:0] S_DIV_DRAIN = 3'd5;

   logic [2:0]       state_q, state_d;
   logic [5:0]       opcode_q, opcode_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic             vin_q, vin_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             accept;

   assign accept = (state_q == S_IDLE) && instr_valid && is_special;

   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      a_d      = a_q;
      b_d      = b_q;
      vin_d    = vin_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (funct)
                  F_MTHI, F_MTLO: begin
                     a_d      = rs_data;
                     opcode_d = funct;
                     state_d  = S_MT;
                  end
                  F_MULT, F_MULTU: begin
                     a_d      = rs_data;
                     b_d      = rt_data;
                     opcode_d = funct;
                     cnt_d    = MUL_LOAD;
                     state_d  = S_MUL;
                  end
                  F_DIV, F_DIVU: begin
                     a_d      = rs_data;
                     b_d      = rt_data;
                     opcode_d = funct;
                     vin_d    = 1'b1;
                     state_d  = S_DIV_START;
                  end
                  default: ;
               endcase
            end
         end
         S_MT: begin
            state_d  = S_IDLE;
            opcode_d = 6'b000000;
            vin_d    = 1'b0;
         end
         S_MUL: begin
            if (cnt_q == '0) begin
               state_d  = S_IDLE;
               opcode_d = 6'b000000;
               vin_d    = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         // unit_valid_out may still be high from the previous divide here, so it is not looked at
         S_DIV_START: begin
            state_d = S_DIV_RUN;
            vin_d   = 1'b0;
            cnt_d   = '0;
         end
         S_DIV_RUN: begin
            if (unit_valid_out) begin
               state_d = S_DIV_DRAIN;
            end else if (cnt_q == DIV_LAST) begin
               state_d  = S_IDLE;
               opcode_d = 6'b000000;
               vin_d    = 1'b0;
               err_d    = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DIV_DRAIN: begin
            state_d  = S_IDLE;
            opcode_d = 6'b000000;
            vin_d    = 1'b0;
         end
         default: begin
            state_d  = S_IDLE;
            opcode_d = 6'b000000;
            vin_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         opcode_q <= 6'b000000;
         a_q      <= '0;
         b_q      <= '0;
         vin_q    <= 1'b0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
         a_q      <= a_d;
         b_q      <= b_d;
         vin_q    <= vin_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   // mfhi/mflo complete in the accept cycle without touching the FSM
   always_comb begin
      mf_valid = 1'b0;
      mf_data  = '0;
      if (accept && (funct == F_MFHI)) begin
         mf_valid = 1'b1;
         mf_data  = hi_in;
      end else if (accept && (funct == F_MFLO)) begin
         mf_valid = 1'b1;
         mf_data  = lo_in;
      end
   end

   assign stall         = (state_q != S_IDLE);
   assign unit_opcode   = opcode_q;
   assign unit_a        = a_q;
   assign unit_b        = b_q;
   assign unit_valid_in = vin_q;
   assign div_err       = err_q;

endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// Bench for mips_cpu_muldiv_ctrl with a small HI/LO unit model (34-iteration divider).
module tb_mips_cpu_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        instr_valid = 1'b0;
   logic        is_special = 1'b0;
   logic [5:0]  funct = 6'b000000;
   logic [31:0] rs_data = '0;
   logic [31:0] rt_data = '0;
   logic        stall;
   logic [5:0]  unit_opcode;
   logic [31:0] unit_a;
   logic [31:0] unit_b;
   logic        unit_valid_in;
   logic        unit_valid_out;
   logic [31:0] hi_in;
   logic [31:0] lo_in;
   logic [31:0] mf_data;
   logic        mf_valid;
   logic        div_err;

   int n_chk  = 0;
   int n_fail = 0;
   logic [31:0] exp_q[$];

   mips_cpu_muldiv_ctrl #(.MUL_CYCLES(2), .DIV_TIMEOUT(48)) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .is_special(is_special),
      .funct(funct), .rs_data(rs_data), .rt_data(rt_data), .stall(stall),
      .unit_opcode(unit_opcode), .unit_a(unit_a), .unit_b(unit_b),
      .unit_valid_in(unit_valid_in), .unit_valid_out(unit_valid_out),
      .hi_in(hi_in), .lo_in(lo_in), .mf_data(mf_data), .mf_valid(mf_valid),
      .div_err(div_err)
   );

   always #5 clk = ~clk;

   // HI/LO unit model
   logic [31:0] hi_r = '0, lo_r = '0;
   logic [5:0]  dcnt = '0;
   logic        vo_r = 1'b0;
   logic        hang = 1'b0;
   logic [63:0] prod_s, prod_u;
   assign hi_in = hi_r;
   assign lo_in = lo_r;
   assign unit_valid_out = vo_r & ~hang;
   assign prod_s = {{32{unit_a[31]}}, unit_a} * {{32{unit_b[31]}}, unit_b};
   assign prod_u = {32'b0, unit_a} * {32'b0, unit_b};

   always @(posedge clk) begin
      case (unit_opcode)
         6'b010001: hi_r <= unit_a;
         6'b010011: lo_r <= unit_a;
         6'b011000: begin hi_r <= prod_s[63:32]; lo_r <= prod_s[31:0]; end
         6'b011001: begin hi_r <= prod_u[63:32]; lo_r <= prod_u[31:0]; end
         6'b011010: if (unit_valid_out && unit_b != 0) begin
            lo_r <= $signed(unit_a) / $signed(unit_b);
            hi_r <= $signed(unit_a) % $signed(unit_b);
         end
         6'b011011: if (unit_valid_out && unit_b != 0) begin
            lo_r <= unit_a / unit_b;
            hi_r <= unit_a % unit_b;
         end
         default: ;
      endcase
      if (unit_valid_in) begin
         dcnt <= 6'd34;
         vo_r <= 1'b0;
      end else if (dcnt != 0) begin
         dcnt <= dcnt - 6'd1;
         if (dcnt == 6'd1) vo_r <= 1'b1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
      end
   endtask

   // monitor: every mf_valid cycle consumes one expected read result
   always @(negedge clk) begin
      if (mf_valid) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL mf_unexpected: got 0x%08h expected no read", mf_data);
         end else begin
            chk("mf_data", mf_data, exp_q.pop_front());
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                        input logic sp);
      instr_valid = 1'b1;
      is_special  = sp;
      funct       = f;
      rs_data     = rs;
      rt_data     = rt;
      cyc();
      instr_valid = 1'b0;
      is_special  = 1'b0;
   endtask

   task automatic do_mf(input logic [5:0] f, input logic [31:0] expv);
      exp_q.push_back(expv);
      issue(f, 32'h0, 32'h0, 1'b1);
   endtask

   task automatic run_div(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                          input int exp_n, input string tag);
      int n;
      issue(f, rs, rt, 1'b1);
      chk({tag, " vin_t1"}, 32'(unit_valid_in), 32'd1);
      chk({tag, " op_t1"}, 32'(unit_opcode), 32'(f));
      chk({tag, " stall_t1"}, 32'(stall), 32'd1);
      cyc();
      chk({tag, " vin_t2"}, 32'(unit_valid_in), 32'd0);
      n = 2;
      while (stall && n < 200) begin
         if (n == exp_n - 1) chk({tag, " op_last"}, 32'(unit_opcode), 32'(f));
         cyc();
         n++;
      end
      chk({tag, " idle_cycle"}, 32'(n), 32'(exp_n));
      chk({tag, " op_idle"}, 32'(unit_opcode), 32'd0);
   endtask

   initial begin
      // reset
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
      chk("rst stall", 32'(stall), 32'd0);
      chk("rst opcode", 32'(unit_opcode), 32'd0);
      chk("rst unit_a", unit_a, 32'd0);
      chk("rst unit_b", unit_b, 32'd0);
      chk("rst vin", 32'(unit_valid_in), 32'd0);
      chk("rst div_err", 32'(div_err), 32'd0);
      chk("rst mf_valid", 32'(mf_valid), 32'd0);

      // mthi then mfhi at T+2
      issue(6'b010001, 32'h12345678, 32'h0, 1'b1);
      chk("mthi stall_t1", 32'(stall), 32'd1);
      chk("mthi op_t1", 32'(unit_opcode), 32'h11);
      chk("mthi a_t1", unit_a, 32'h12345678);
      cyc();
      chk("mthi stall_t2", 32'(stall), 32'd0);
      chk("mthi op_t2", 32'(unit_opcode), 32'd0);
      do_mf(6'b010000, 32'h12345678);

      // ignored: non-HI/LO funct, and HI/LO funct with is_special low
      issue(6'b100000, 32'h1, 32'h2, 1'b1);
      chk("add ignored stall", 32'(stall), 32'd0);
      issue(6'b010011, 32'hDEAD0000, 32'h0, 1'b0);
      chk("nonspecial ignored stall", 32'(stall), 32'd0);
      chk("nonspecial ignored op", 32'(unit_opcode), 32'd0);

      // multu 0xFFFFFFFF * 2, with an mfhi presented while stalled
      issue(6'b011001, 32'hFFFFFFFF, 32'h2, 1'b1);
      chk("multu stall_t1", 32'(stall), 32'd1);
      chk("multu op_t1", 32'(unit_opcode), 32'h19);
      chk("multu b_t1", unit_b, 32'h2);
      instr_valid = 1'b1;
      is_special  = 1'b1;
      funct       = 6'b010000;
      #1;
      chk("mf while stalled", 32'(mf_valid), 32'd0);
      cyc();
      instr_valid = 1'b0;
      is_special  = 1'b0;
      chk("multu stall_t2", 32'(stall), 32'd1);
      chk("multu op_t2", 32'(unit_opcode), 32'h19);
      cyc();
      chk("multu stall_t3", 32'(stall), 32'd0);
      chk("multu op_t3", 32'(unit_opcode), 32'd0);
      do_mf(6'b010000, 32'h00000001);
      do_mf(6'b010010, 32'hFFFFFFFE);

      // divu 100/7, then signed div with stale done still high
      run_div(6'b011011, 32'd100, 32'd7, 38, "divu");
      do_mf(6'b010010, 32'd14);
      do_mf(6'b010000, 32'd2);
      chk("stale done high", 32'(unit_valid_out), 32'd1);
      run_div(6'b011010, 32'hFFFFFFF9, 32'd2, 38, "div");
      do_mf(6'b010010, 32'hFFFFFFFD);
      do_mf(6'b010000, 32'hFFFFFFFF);
      chk("div_err clean", 32'(div_err), 32'd0);

      // divider never completes: 48 DIV_RUN cycles then abort
      hang = 1'b1;
      run_div(6'b011011, 32'd5, 32'd1, 50, "timeout");
      chk("timeout div_err", 32'(div_err), 32'd1);
      hang = 1'b0;
      cyc();
      cyc();
      chk("div_err sticky", 32'(div_err), 32'd1);

      // reset in the middle of a divu
      issue(6'b011011, 32'd100, 32'd7, 1'b1);
      for (int i = 0; i < 9; i++) cyc();
      chk("pre-reset stall", 32'(stall), 32'd1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("midrst stall", 32'(stall), 32'd0);
      chk("midrst opcode", 32'(unit_opcode), 32'd0);
      chk("midrst div_err", 32'(div_err), 32'd0);
      chk("midrst vin", 32'(unit_valid_in), 32'd0);
      issue(6'b010011, 32'hCAFEF00D, 32'h0, 1'b1);
      chk("mtlo stall_t1", 32'(stall), 32'd1);
      chk("mtlo op_t1", 32'(unit_opcode), 32'h13);
      cyc();
      chk("mtlo stall_t2", 32'(stall), 32'd0);
      do_mf(6'b010010, 32'hCAFEF00D);

      cyc();
      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
